// File: rtl/pixel_float_sequencer_pkg.sv
// ============================================================================
// Module  : pixel_float_sequencer_pkg
// Brief   : Shared state encoding and default sizing for the pixel sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pixel_float_sequencer_pkg;

    localparam int FLOAT_W      = 32;
    localparam int NPIX_DEFAULT = 784;
    localparam int AW_DEFAULT   = 10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/pixel_float_sequencer_floatconvert.sv
// ============================================================================
// Module  : floatconvert
// Brief   : Combinational unsigned byte to IEEE-754 single-precision converter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module floatconvert
    import pixel_float_sequencer_pkg::*;
(
    input  logic [7:0]         pixel,
    output logic [FLOAT_W-1:0] float_word
);

    logic [2:0] w_msb;
    logic [7:0] w_norm;

    always_comb begin
        w_msb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pixel[i]) begin
                w_msb = 3'(i);
            end
        end
        // Left-justify so the hidden one sits in bit 7; the rest is the fraction.
        w_norm = pixel << (3'd7 - w_msb);
        if (pixel == 8'd0) begin
            float_word = '0;
        end else begin
            float_word = {1'b0, 8'd127 + {5'd0, w_msb}, w_norm[6:0], 16'd0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_float_sequencer.sv
// ============================================================================
// Module  : pixel_float_sequencer
// Brief   : Reads a pixel frame from RAM, converts each byte to float and
//           streams it on a valid/ready port. Macro PIXEL_INVERT_EN inverts
//           each pixel (255-p) before conversion.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_float_sequencer
    import pixel_float_sequencer_pkg::*;
#(
    parameter int NPIX = NPIX_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               mem_rd,
    output logic [AW-1:0]      mem_addr,
    input  logic [7:0]         mem_data,
    output logic [FLOAT_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [AW-1:0]      out_index
);

    localparam logic [AW-1:0] C_LAST_IDX = AW'(NPIX - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [AW-1:0]      r_idx;
    logic [FLOAT_W-1:0] r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic [AW-1:0]      r_out_index;
    logic [7:0]         w_conv_in;
    logic [FLOAT_W-1:0] w_conv_out;
    logic               w_abort;
    logic               w_accept;

    assign w_abort  = abort && (r_state != ST_IDLE);
    assign w_accept = (r_state == ST_SEND) && out_ready && !abort;

`ifdef PIXEL_INVERT_EN
    assign w_conv_in = 8'd255 - mem_data;
`else
    assign w_conv_in = mem_data;
`endif

    floatconvert u_floatconvert (
        .pixel      (w_conv_in),
        .float_word (w_conv_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_READ;
            ST_READ: w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_SEND;
            ST_SEND: if (out_ready) w_state_nxt = r_out_last ? ST_FIN : ST_READ;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        busy   = (r_state != ST_IDLE);
        done   = (r_state == ST_FIN) && !abort;
        mem_rd = (r_state == ST_READ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_index <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_idx <= '0;
            end else if (w_accept && !r_out_last) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_abort) begin
                r_out_valid <= 1'b0;
            end else if (r_state == ST_LOAD) begin
                r_out_data  <= w_conv_out;
                r_out_valid <= 1'b1;
                r_out_index <= r_idx;
                r_out_last  <= (r_idx == C_LAST_IDX);
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // The index only moves on entry to READ, so it doubles as the held address.
    assign mem_addr  = r_idx;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_index = r_out_index;

endmodule

`default_nettype wire

// File: tb/tb_pixel_float_sequencer.sv
// ============================================================================
// Module  : tb_pixel_float_sequencer
// Brief   : Randomised self-checking bench against a behavioural frame model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_float_sequencer;

    localparam int NPIX = 4;
    localparam int AW   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic        busy, done, mem_rd, out_valid, out_last;
    logic [AW-1:0] mem_addr, out_index;
    logic [7:0]  mem_data = 8'd0;
    logic [31:0] out_data;
    logic [7:0]  ram [16];

    logic        start1 = 1'b0;
    logic        busy1, done1, mem_rd1, out_valid1, out_last1;
    logic [AW-1:0] mem_addr1, out_index1;
    logic [7:0]  mem_data1 = 8'd0;
    logic [31:0] out_data1;
    logic [7:0]  ram1_val = 8'd7;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pixel_float_sequencer #(.NPIX(NPIX), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_index(out_index)
    );

    pixel_float_sequencer #(.NPIX(1), .AW(AW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .busy(busy1), .done(done1),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_data(mem_data1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(1'b1), .out_last(out_last1), .out_index(out_index1)
    );

    always @(posedge clk) begin
        if (mem_rd)  mem_data  <= ram[mem_addr];
        if (mem_rd1) mem_data1 <= ram1_val;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Float value of a byte from its binary logarithm and remainder.
    function automatic logic [31:0] ref_float(input int v);
        int p, e;
        p = v;
`ifdef PIXEL_INVERT_EN
        p = 255 - v;
`endif
        if (p == 0) return 32'd0;
        e = 0;
        while ((1 << (e + 1)) <= p) e++;
        return {1'b0, 8'(127 + e), 23'((p - (1 << e)) << (23 - e))};
    endfunction

    task automatic run_frame(input int stall_at, input int stall_len, input int abort_at, input bit noise);
        int k = 0, stalled = 0, cyc = 0;
        bit fin = 0, aborted = 0, hold_v = 0;
        logic [31:0] hold_d;
        logic [AW-1:0] hold_i;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        while (!fin && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = !(k == stall_at && stalled < stall_len);
            abort     = (k == abort_at) && out_valid;
            @(negedge clk);
            if (mem_rd) check_eq("rd_addr", 32'(mem_addr), 32'(k));
            if (out_valid && !out_ready) begin
                stalled++;
                check_eq("stall_no_rd", 32'(mem_rd), 32'd0);
                if (hold_v) begin
                    check_eq("hold_data", out_data, hold_d);
                    check_eq("hold_index", 32'(out_index), 32'(hold_i));
                end
                hold_v = 1; hold_d = out_data; hold_i = out_index;
            end else begin
                hold_v = 0;
            end
            if (abort) begin
                aborted = 1;
                fin = 1;
            end else if (out_valid && out_ready) begin
                check_eq("out_data", out_data, ref_float(int'(ram[k])));
                check_eq("out_index", 32'(out_index), 32'(k));
                check_eq("out_last", 32'(out_last), 32'(k == NPIX - 1));
                k++;
            end
            if (done) begin
                check_eq("done_cycle", 32'(cyc), 32'(3 * NPIX + 1 + stall_len));
                check_eq("word_count", 32'(k), 32'(NPIX));
                fin = 1;
            end
        end
        check_eq("frame_end", 32'(fin), 32'd1);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        if (aborted) begin
            check_eq("abort_valid", 32'(out_valid), 32'd0);
            check_eq("abort_busy", 32'(busy), 32'd0);
            repeat (4) begin
                @(negedge clk);
                check_eq("abort_no_done", 32'(done), 32'd0);
            end
        end else begin
            check_eq("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        ram[0] = 8'd0; ram[1] = 8'd1; ram[2] = 8'd128; ram[3] = 8'd255;
        run_frame(99, 0, 99, 0);
        run_frame(2, 5, 99, 0);
        run_frame(99, 0, 1, 0);
        run_frame(99, 0, 99, 0);

        for (int n = 0; n < 6; n++) begin
            fill_ram();
            run_frame(int'($urandom_range(0, NPIX - 1)), int'($urandom_range(1, 6)), 99, 1);
        end
        fill_ram();
        run_frame(99, 0, int'($urandom_range(0, NPIX - 1)), 0);

        // Asynchronous reset landing in LOAD of the first pixel.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_data", out_data, 32'd0);
        check_eq("arst_index", 32'(out_index), 32'd0);
        check_eq("arst_last", 32'(out_last), 32'd0);
        check_eq("arst_rd", 32'(mem_rd), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_ram();
        run_frame(99, 0, 99, 0);

        // Single-pixel frame on the second instance, with extra STARTs while busy.
        begin
            int cyc1 = 0;
            int words1 = 0;
            bit seen_done = 0;
            @(posedge clk); #1 start1 = 1'b1;
            @(negedge clk);
            while (!seen_done && cyc1 < 50) begin
                @(posedge clk); #1;
                cyc1++;
                start1 = busy1;
                @(negedge clk);
                if (out_valid1) begin
                    check_eq("n1_data", out_data1, ref_float(7));
                    check_eq("n1_last", 32'(out_last1), 32'd1);
                    check_eq("n1_index", 32'(out_index1), 32'd0);
                    words1++;
                end
                if (done1) begin
                    check_eq("n1_done_cycle", 32'(cyc1), 32'd4);
                    seen_done = 1;
                end
            end
            check_eq("n1_seen_done", 32'(seen_done), 32'd1);
            check_eq("n1_words", 32'(words1), 32'd1);
            @(posedge clk); #1 start1 = 1'b0;
            @(negedge clk);
            check_eq("n1_idle", 32'(busy1), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
